// File: rtl/rc4_crack_core_pkg.sv
// Shared types and helpers for the RC4 key-search core: FSM state encoding,
// byte type, S-box size, and the plaintext character-class check.
package rc4_pkg;

    localparam int SBOX_SIZE = 256;

    typedef logic [7:0] byte_t;

    localparam byte_t SPACE_CHAR = 8'h20;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        INIT      = 4'd1,
        KSA_J     = 4'd2,
        KSA_SWAP  = 4'd3,
        PRGA_IJ   = 4'd4,
        PRGA_SWAP = 4'd5,
        PRGA_OUT  = 4'd6,
        NEXT      = 4'd7,
        FOUND     = 4'd8,
        EXHAUST   = 4'd9
    } rc4_state_t;

    // A plaintext byte is acceptable if it falls in [lo, hi], or is a space
    // when spaces are allowed.
    function automatic logic is_valid_char(input byte_t b, input byte_t lo,
                                           input byte_t hi, input logic allow_space);
        is_valid_char = ((b >= lo) && (b <= hi)) || (allow_space && (b == SPACE_CHAR));
    endfunction

endpackage

// File: rtl/rc4_crack_core_sbox.sv
// 256-entry RC4 permutation store: two combinational read ports and two
// write ports. Contents are not reset; INIT rebuilds them for every key.
// On a write address collision port B takes effect.
module rc4_sbox
    import rc4_pkg::*;
(
    input  logic  clk,
    input  byte_t i_ra_addr,
    output byte_t o_ra_data,
    input  byte_t i_rb_addr,
    output byte_t o_rb_data,
    input  logic  i_wa_en,
    input  byte_t i_wa_addr,
    input  byte_t i_wa_data,
    input  logic  i_wb_en,
    input  byte_t i_wb_addr,
    input  byte_t i_wb_data
);

    byte_t r_mem [SBOX_SIZE];

    assign o_ra_data = r_mem[i_ra_addr];
    assign o_rb_data = r_mem[i_rb_addr];

    // Dual write; port B is applied last so it wins on the same address.
    always_ff @(posedge clk) begin
        if (i_wa_en) r_mem[i_wa_addr] <= i_wa_data;
        if (i_wb_en) r_mem[i_wb_addr] <= i_wb_data;
    end

endmodule

// File: rtl/rc4_crack_core.sv
// RC4 brute-force search core. Walks key_start, key_start+stride, ... up to
// key_last; for each key runs INIT, KSA and PRGA over the internal
// ciphertext buffer and checks the plaintext character class.
// Optional macro RC4_EARLY_ABORT_EN: abandon a key at its first bad byte.
module rc4_crack_core
    import rc4_pkg::*;
#(
    parameter int    KEY_BYTES   = 3,
    parameter int    MSG_LEN     = 32,
    parameter byte_t CHAR_LO     = 8'h61,
    parameter byte_t CHAR_HI     = 8'h7A,
    parameter bit    ALLOW_SPACE = 1'b1,
    localparam int   KW          = 8 * KEY_BYTES,
    localparam int   AW          = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
)(
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          stop_all,
    input  logic [KW-1:0] key_start,
    input  logic [KW-1:0] key_stride,
    input  logic [KW-1:0] key_last,
    input  logic          ct_wr_en,
    input  logic [AW-1:0] ct_wr_addr,
    input  logic [7:0]    ct_wr_data,
    input  logic [AW-1:0] pt_rd_addr,
    output logic [7:0]    pt_rd_data,
    output logic          busy,
    output logic          found,
    output logic          exhausted,
    output logic [KW-1:0] key_out
);

    localparam int KIW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

    rc4_state_t     r_state;
    byte_t          r_i, r_j, r_t;
    logic [AW-1:0]  r_n;
    logic [KIW-1:0] r_kidx;
    logic           r_bad;
    logic           r_busy, r_found, r_exhausted;
    logic [KW-1:0]  r_key;
    byte_t          r_ct [MSG_LEN];
    byte_t          r_pt [MSG_LEN];

    byte_t          w_ra_addr, w_rb_addr, w_ra_data, w_rb_data;
    logic           w_wa_en, w_wb_en;
    byte_t          w_wa_addr, w_wa_data, w_wb_addr, w_wb_data;
    byte_t          w_key_byte, w_pt_byte;
    logic           w_pt_valid, w_n_last;
    logic [KW:0]    w_sum;

    rc4_sbox u_sbox (
        .clk       (clk),
        .i_ra_addr (w_ra_addr),
        .o_ra_data (w_ra_data),
        .i_rb_addr (w_rb_addr),
        .o_rb_data (w_rb_data),
        .i_wa_en   (w_wa_en),
        .i_wa_addr (w_wa_addr),
        .i_wa_data (w_wa_data),
        .i_wb_en   (w_wb_en),
        .i_wb_addr (w_wb_addr),
        .i_wb_data (w_wb_data)
    );

    // Key bytes are taken most significant first.
    assign w_key_byte = byte_t'(r_key >> (8 * (KEY_BYTES - 1 - int'(r_kidx))));
    assign w_pt_byte  = r_ct[r_n] ^ w_ra_data;
    assign w_pt_valid = is_valid_char(w_pt_byte, CHAR_LO, CHAR_HI, ALLOW_SPACE);
    assign w_n_last   = (r_n == AW'(MSG_LEN - 1));
    assign w_sum      = {1'b0, r_key} + {1'b0, key_stride};

    assign pt_rd_data = r_pt[pt_rd_addr];
    assign busy       = r_busy;
    assign found      = r_found;
    assign exhausted  = r_exhausted;
    assign key_out    = r_key;

    // S-box port steering per state. Swaps cross-write the two read values;
    // in PRGA_OUT port A fetches S[S[i]+S[j]] using the sum captured earlier.
    always_comb begin
        w_ra_addr = r_i;
        w_rb_addr = r_j;
        w_wa_en   = 1'b0;
        w_wa_addr = r_i;
        w_wa_data = w_rb_data;
        w_wb_en   = 1'b0;
        w_wb_addr = r_j;
        w_wb_data = w_ra_data;
        case (r_state)
            INIT: begin
                w_wa_en   = 1'b1;
                w_wa_data = r_i;
            end
            KSA_SWAP, PRGA_SWAP: begin
                w_wa_en = 1'b1;
                w_wb_en = 1'b1;
            end
            PRGA_IJ:  w_ra_addr = r_i + 8'd1;
            PRGA_OUT: w_ra_addr = r_t;
            default: begin
                w_wa_en = 1'b0;
                w_wb_en = 1'b0;
            end
        endcase
    end

    // Ciphertext buffer write port (no reset).
    always_ff @(posedge clk) begin
        if (ct_wr_en) r_ct[ct_wr_addr] <= ct_wr_data;
    end

    // Plaintext buffer capture during PRGA_OUT (no reset).
    always_ff @(posedge clk) begin
        if (r_state == PRGA_OUT) r_pt[r_n] <= w_pt_byte;
    end

    // Search FSM with registered status outputs; stop_all overrides any busy state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_i         <= 8'd0;
            r_j         <= 8'd0;
            r_t         <= 8'd0;
            r_n         <= '0;
            r_kidx      <= '0;
            r_bad       <= 1'b0;
            r_busy      <= 1'b0;
            r_found     <= 1'b0;
            r_exhausted <= 1'b0;
            r_key       <= '0;
        end else if (stop_all && r_busy) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, FOUND, EXHAUST: begin
                    if (start) begin
                        r_key       <= key_start;
                        r_busy      <= 1'b1;
                        r_found     <= 1'b0;
                        r_exhausted <= 1'b0;
                        r_i         <= 8'd0;
                        r_j         <= 8'd0;
                        r_kidx      <= '0;
                        r_bad       <= 1'b0;
                        r_state     <= INIT;
                    end
                end
                INIT: begin
                    r_i <= r_i + 8'd1;
                    if (r_i == 8'hFF) begin
                        r_j     <= 8'd0;
                        r_kidx  <= '0;
                        r_state <= KSA_J;
                    end
                end
                KSA_J: begin
                    r_j     <= r_j + w_ra_data + w_key_byte;
                    r_state <= KSA_SWAP;
                end
                KSA_SWAP: begin
                    r_i    <= r_i + 8'd1;
                    r_kidx <= (r_kidx == KIW'(KEY_BYTES - 1)) ? '0 : r_kidx + KIW'(1);
                    if (r_i == 8'hFF) begin
                        r_j     <= 8'd0;
                        r_n     <= '0;
                        r_state <= PRGA_IJ;
                    end else begin
                        r_state <= KSA_J;
                    end
                end
                PRGA_IJ: begin
                    r_i     <= r_i + 8'd1;
                    r_j     <= r_j + w_ra_data;
                    r_state <= PRGA_SWAP;
                end
                PRGA_SWAP: begin
                    // Sum is swap-invariant, so capture it from pre-swap values.
                    r_t     <= w_ra_data + w_rb_data;
                    r_state <= PRGA_OUT;
                end
                PRGA_OUT: begin
                    r_n <= r_n + AW'(1);
                    if (!w_pt_valid) r_bad <= 1'b1;
`ifdef RC4_EARLY_ABORT_EN
                    if (!w_pt_valid || w_n_last) r_state <= NEXT;
                    else                         r_state <= PRGA_IJ;
`else
                    if (w_n_last) r_state <= NEXT;
                    else          r_state <= PRGA_IJ;
`endif
                end
                NEXT: begin
                    if (!r_bad) begin
                        r_found <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= FOUND;
                    end else if (w_sum[KW] || (w_sum[KW-1:0] > key_last)) begin
                        r_exhausted <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= EXHAUST;
                    end else begin
                        r_key   <= w_sum[KW-1:0];
                        r_i     <= 8'd0;
                        r_j     <= 8'd0;
                        r_kidx  <= '0;
                        r_bad   <= 1'b0;
                        r_state <= INIT;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rc4_crack_core.sv
// Self-checking bench for rc4_crack_core. Reference model is plain RC4 over
// integer arrays plus a key-walk loop that predicts outcome and per-key latency.
`timescale 1ns/1ps
module tb_rc4_crack_core;

    localparam int KB = 3;
    localparam int KW = 24;
    localparam int ML = 32;
    localparam int AW = 5;
    localparam int FULL_LAT = 256 + 512 + 3 * ML + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n, start, start2, stop_all, ct_wr_en;
    logic [KW-1:0] key_start, key_stride, key_last;
    logic [AW-1:0] ct_wr_addr, pt_rd_addr;
    logic [7:0]    ct_wr_data, pt_rd_data, pt_rd_data2;
    logic          busy, found, exhausted, busy2, found2, exhausted2;
    logic [KW-1:0] key_out, key_out2;

    rc4_crack_core dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stop_all(stop_all),
        .key_start(key_start), .key_stride(key_stride), .key_last(key_last),
        .ct_wr_en(ct_wr_en), .ct_wr_addr(ct_wr_addr), .ct_wr_data(ct_wr_data),
        .pt_rd_addr(pt_rd_addr), .pt_rd_data(pt_rd_data),
        .busy(busy), .found(found), .exhausted(exhausted), .key_out(key_out)
    );

    rc4_crack_core #(.ALLOW_SPACE(1'b0)) dut_nosp (
        .clk(clk), .reset_n(reset_n), .start(start2), .stop_all(stop_all),
        .key_start(key_start), .key_stride(key_stride), .key_last(key_last),
        .ct_wr_en(ct_wr_en), .ct_wr_addr(ct_wr_addr), .ct_wr_data(ct_wr_data),
        .pt_rd_addr(pt_rd_addr), .pt_rd_data(pt_rd_data2),
        .busy(busy2), .found(found2), .exhausted(exhausted2), .key_out(key_out2)
    );

    int n_total = 0;
    int n_bad   = 0;
    logic [7:0] pt_m [ML];
    logic [7:0] ct_m [ML];
    logic [7:0] ks_m [ML];
    int exp_lat [$];
    int obs_lat [$];

    function automatic bit char_ok(input logic [7:0] p, input bit sp);
        return ((p >= 8'h61) && (p <= 8'h7A)) || (sp && (p == 8'h20));
    endfunction

    // Textbook RC4: KSA then ML bytes of keystream into ks_m.
    task automatic gen_ks(input logic [KW-1:0] key);
        int s [256];
        int i, j, t, kb;
        for (int x = 0; x < 256; x++) s[x] = x;
        j = 0;
        for (int x = 0; x < 256; x++) begin
            kb = int'((key >> (8 * (KB - 1 - (x % KB)))) & 24'hFF);
            j = (j + s[x] + kb) % 256;
            t = s[x]; s[x] = s[j]; s[j] = t;
        end
        i = 0; j = 0;
        for (int n = 0; n < ML; n++) begin
            i = (i + 1) % 256;
            j = (j + s[i]) % 256;
            t = s[i]; s[i] = s[j]; s[j] = t;
            ks_m[n] = 8'(s[(s[i] + s[j]) % 256]);
        end
    endtask

    task automatic encrypt(input logic [KW-1:0] key);
        gen_ks(key);
        for (int n = 0; n < ML; n++) ct_m[n] = pt_m[n] ^ ks_m[n];
    endtask

    task automatic key_ok(input logic [KW-1:0] key, input bit sp, output bit ok, output int fb);
        logic [7:0] p;
        gen_ks(key);
        ok = 1'b1; fb = -1;
        for (int n = 0; n < ML; n++) begin
            p = ct_m[n] ^ ks_m[n];
            if (!char_ok(p, sp) && ok) begin ok = 1'b0; fb = n; end
        end
    endtask

    // Walks the key range like the spec describes; fills exp_lat per key.
    task automatic predict(input logic [KW-1:0] ks, input logic [KW-1:0] st,
                           input logic [KW-1:0] kl, input bit sp,
                           output bit e_found, output logic [KW-1:0] e_key);
        logic [KW:0]   sum;
        logic [KW-1:0] k;
        bit ok;
        int fb;
        exp_lat.delete();
        k = ks; e_found = 1'b0; e_key = ks;
        for (int g = 0; g < 4096; g++) begin
            key_ok(k, sp, ok, fb);
            e_key = k;
            if (ok) begin
                exp_lat.push_back(FULL_LAT);
                e_found = 1'b1;
                return;
            end
`ifdef RC4_EARLY_ABORT_EN
            exp_lat.push_back(256 + 512 + 3 * (fb + 1) + 1);
`else
            exp_lat.push_back(FULL_LAT);
`endif
            sum = {1'b0, k} + {1'b0, st};
            if (sum[KW] || (sum[KW-1:0] > kl)) return;
            k = sum[KW-1:0];
        end
    endtask

    task automatic load_ct();
        for (int n = 0; n < ML; n++) begin
            ct_wr_en = 1'b1; ct_wr_addr = AW'(n); ct_wr_data = ct_m[n];
            @(negedge clk);
        end
        ct_wr_en = 1'b0;
    endtask

    task automatic rand_text(input int spaces);
        for (int n = 0; n < ML; n++) pt_m[n] = 8'(8'h61 + $urandom_range(0, 25));
        for (int s = 0; s < spaces; s++) pt_m[$urandom_range(0, ML - 1)] = 8'h20;
    endtask

    // Starts dut, records cycles between key changes and to completion.
    task automatic run_search(input logic [KW-1:0] ks, input logic [KW-1:0] st,
                              input logic [KW-1:0] kl, input int budget, output bit to);
        int cnt;
        logic [KW-1:0] prev;
        key_start = ks; key_stride = st; key_last = kl;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        obs_lat.delete();
        prev = key_out; cnt = 0; to = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            cnt++;
            if (key_out !== prev) begin
                obs_lat.push_back(cnt); cnt = 0; prev = key_out;
            end
            if (!busy) begin
                obs_lat.push_back(cnt); to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; start2 = 1'b0; stop_all = 1'b0; ct_wr_en = 1'b0;
        ct_wr_addr = '0; ct_wr_data = 8'h00; pt_rd_addr = '0;
        key_start = '0; key_stride = 24'd1; key_last = '0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({busy, found, exhausted, key_out} !== {3'b000, 24'h0}) begin
            n_bad++;
            $display("FAIL reset_state: got b=%b f=%b e=%b k=%h want all 0", busy, found, exhausted, key_out);
        end
        n_total++;
        if ({busy2, found2, exhausted2} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_state2: got %b want 000", {busy2, found2, exhausted2});
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_known_hit();
        string txt;
        bit e_found, to;
        logic [KW-1:0] e_key;
        txt = "attack at dawn and hold the hill";
        for (int n = 0; n < ML; n++) pt_m[n] = txt[n];
        encrypt(24'h000249);
        load_ct();
        predict(24'h000240, 24'd1, 24'h0002FF, 1'b1, e_found, e_key);
        run_search(24'h000240, 24'd1, 24'h0002FF, 11 * 900, to);
        n_total++;
        if (to) begin n_bad++; $display("FAIL hit_timeout: busy still %b want 0", busy); end
        n_total++;
        if (found !== e_found || exhausted !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL hit_flags: got f=%b e=%b b=%b want f=%b e=0 b=0", found, exhausted, busy, e_found);
        end
        n_total++;
        if (key_out !== e_key) begin
            n_bad++; $display("FAIL hit_key: got %h want %h", key_out, e_key);
        end
        n_total++;
        if (obs_lat.size() != exp_lat.size()) begin
            n_bad++; $display("FAIL hit_attempts: got %0d want %0d", obs_lat.size(), exp_lat.size());
        end
        for (int n = 0; n < ML; n++) begin
            pt_rd_addr = AW'(n);
            #1;
            n_total++;
            if (pt_rd_data !== pt_m[n]) begin
                n_bad++; $display("FAIL hit_pt[%0d]: got %h want %h", n, pt_rd_data, pt_m[n]);
            end
        end
        @(negedge clk);
    endtask

    // Stride chosen so the real key 0x249 is stepped over.
    task automatic test_strided_latency();
        bit e_found, to;
        logic [KW-1:0] e_key;
        predict(24'h000242, 24'd4, 24'h000300, 1'b1, e_found, e_key);
        run_search(24'h000242, 24'd4, 24'h000300, 50 * 900, to);
        n_total++;
        if (to) begin n_bad++; $display("FAIL miss_timeout: busy still %b want 0", busy); end
        n_total++;
        if (exhausted !== !e_found || found !== e_found) begin
            n_bad++; $display("FAIL miss_flags: got f=%b e=%b want f=%b e=%b", found, exhausted, e_found, !e_found);
        end
        n_total++;
        if (key_out !== e_key) begin
            n_bad++; $display("FAIL miss_key: got %h want %h", key_out, e_key);
        end
        n_total++;
        if (obs_lat.size() != exp_lat.size()) begin
            n_bad++; $display("FAIL miss_attempts: got %0d want %0d", obs_lat.size(), exp_lat.size());
        end else begin
            for (int k = 0; k < exp_lat.size(); k++) begin
                n_total++;
                if (obs_lat[k] != exp_lat[k]) begin
                    n_bad++; $display("FAIL latency[%0d]: got %0d want %0d", k, obs_lat[k], exp_lat[k]);
                end
            end
        end
    endtask

    task automatic test_stop_all();
        bit hit;
        key_start = 24'h000100; key_stride = 24'd1; key_last = 24'h0001FF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 3 * 900; c++) begin
            if (key_out === 24'h000102) begin hit = 1'b1; break; end
            @(negedge clk);
        end
        n_total++;
        if (!hit) begin n_bad++; $display("FAIL stop_reach_key3: got %h want 000102", key_out); end
        repeat (300) @(negedge clk);
        n_total++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL stop_busy_before: got %b want 1", busy); end
        stop_all = 1'b1;
        @(negedge clk);
        n_total++;
        if ({busy, found, exhausted} !== 3'b000 || key_out !== 24'h000102) begin
            n_bad++;
            $display("FAIL stop_state: got b=%b f=%b e=%b k=%h want 0 0 0 000102", busy, found, exhausted, key_out);
        end
        stop_all = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit to, e_found;
        logic [KW-1:0] e_key;
        key_start = 24'h000248; key_stride = 24'd1; key_last = 24'h0002FF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (256 + 512 + 20) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_total++;
        if ({busy, found, exhausted} !== 3'b000 || key_out !== 24'h0) begin
            n_bad++;
            $display("FAIL async_reset: got b=%b f=%b e=%b k=%h want all 0", busy, found, exhausted, key_out);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        predict(24'h000248, 24'd1, 24'h0002FF, 1'b1, e_found, e_key);
        run_search(24'h000248, 24'd1, 24'h0002FF, 3 * 900, to);
        n_total++;
        if (to || found !== e_found || key_out !== e_key || obs_lat.size() != exp_lat.size()) begin
            n_bad++;
            $display("FAIL rerun: got f=%b k=%h n=%0d want f=%b k=%h n=%0d", found, key_out, obs_lat.size(), e_found, e_key, exp_lat.size());
        end
    endtask

    task automatic test_edge_range();
        bit to, e_found;
        logic [KW-1:0] e_key;
        rand_text(0);
        encrypt(24'($urandom_range(0, 24'hFFFFFE)));
        load_ct();
        predict(24'hFFFFFF, 24'd1, 24'hFFFFFF, 1'b1, e_found, e_key);
        run_search(24'hFFFFFF, 24'd1, 24'hFFFFFF, 2 * 900, to);
        n_total++;
        if (to || found !== e_found || exhausted !== !e_found || key_out !== e_key) begin
            n_bad++;
            $display("FAIL edge_range: got f=%b e=%b k=%h want f=%b e=%b k=%h", found, exhausted, key_out, e_found, !e_found, e_key);
        end
        n_total++;
        if (obs_lat.size() != 1) begin
            n_bad++; $display("FAIL edge_attempts: got %0d want 1", obs_lat.size());
        end
    endtask

    task automatic test_space();
        bit ef1, ef0, done;
        logic [KW-1:0] ek1, ek0, key;
        rand_text(3);
        pt_m[$urandom_range(1, ML - 2)] = 8'h20;
        key = 24'($urandom_range(0, 24'hFFFFFF));
        encrypt(key);
        load_ct();
        predict(key, 24'd1, key, 1'b0, ef0, ek0);
        predict(key, 24'd1, key, 1'b1, ef1, ek1);
        key_start = key; key_stride = 24'd1; key_last = key;
        start = 1'b1; start2 = 1'b1;
        @(negedge clk);
        start = 1'b0; start2 = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (!busy && !busy2) begin done = 1'b1; break; end
            @(negedge clk);
        end
        n_total++;
        if (!done) begin n_bad++; $display("FAIL space_timeout: busy=%b busy2=%b want 0 0", busy, busy2); end
        n_total++;
        if (found !== ef1 || key_out !== ek1) begin
            n_bad++; $display("FAIL space_allowed: got f=%b k=%h want f=%b k=%h", found, key_out, ef1, ek1);
        end
        n_total++;
        if (found2 !== ef0 || exhausted2 !== !ef0 || key_out2 !== ek0) begin
            n_bad++; $display("FAIL space_rejected: got f=%b e=%b k=%h want f=%b e=%b k=%h", found2, exhausted2, key_out2, ef0, !ef0, ek0);
        end
    endtask

    task automatic test_random_hit();
        bit to, e_found;
        logic [KW-1:0] e_key, key, ks;
        rand_text(2);
        key = 24'($urandom_range(16, 24'hFFFFF0));
        ks  = key - 24'($urandom_range(0, 3));
        encrypt(key);
        load_ct();
        predict(ks, 24'd1, key + 24'd4, 1'b1, e_found, e_key);
        run_search(ks, 24'd1, key + 24'd4, 9 * 900, to);
        n_total++;
        if (to || found !== e_found || key_out !== e_key) begin
            n_bad++; $display("FAIL random_hit: got f=%b k=%h want f=%b k=%h", found, key_out, e_found, e_key);
        end
        n_total++;
        if (obs_lat.size() != exp_lat.size()) begin
            n_bad++; $display("FAIL random_attempts: got %0d want %0d", obs_lat.size(), exp_lat.size());
        end
    endtask

    initial begin
        test_reset();
        test_known_hit();
        test_strided_latency();
        test_stop_all();
        test_reset_mid();
        test_edge_range();
        test_space();
        test_random_hit();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
